turbo_len_seq: RTL

TURBO_LEN_SEQ -- requirements
Module: turbo_len_seq

---
 rtl/turbo_len_seq_pkg.sv | 19 +
 rtl/turbo_len_fifo.sv | 57 +++++
 rtl/turbo_len_seq.sv | 137 +++++++++++++
 3 files changed

// File: rtl/turbo_len_seq_pkg.sv
// Shared definitions for the turbo interleaver length sequencer: PB size codes,
// default pair-lengths per PB size and the sequencer state type.
package turbo_len_seq_pkg;

  localparam logic [1:0] PB_SIZE_16     = 2'b00;
  localparam logic [1:0] PB_SIZE_136    = 2'b01;
  localparam logic [1:0] PB_SIZE_520    = 2'b10;
  localparam logic [1:0] PB_SIZE_CUSTOM = 2'b11;

  localparam int LEN_PB16_DEF  = 64;
  localparam int LEN_PB136_DEF = 544;
  localparam int LEN_PB520_DEF = 2080;

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

endpackage

// File: rtl/turbo_len_fifo.sv
// Command FIFO for the length sequencer; each entry carries a PB length and its
// burst_end flag. wr_rdy is a registered "not full" that tracks the next count.
module turbo_len_fifo #(
  parameter int ADDR_W = 12,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              push,
  input  logic [ADDR_W-1:0] wr_len,
  input  logic              wr_end,
  input  logic              pop,
  output logic [ADDR_W-1:0] rd_len,
  output logic              rd_end,
  output logic              empty,
  output logic              wr_rdy
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0]   FULL_CNT = (PW + 1)'(DEPTH);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);

  logic [ADDR_W:0] mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [PW:0]     count;
  logic [PW:0]     count_nxt;

  always_comb begin
    count_nxt = count + (PW + 1)'(push) - (PW + 1)'(pop);
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      wr_rdy <= !rst;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      count  <= count_nxt;
      wr_rdy <= (count_nxt != FULL_CNT);
    end
  end

  // Payload storage needs no reset: entries are only read while count says valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {wr_end, wr_len};
  end

  assign rd_len = mem[rd_ptr][ADDR_W-1:0];
  assign rd_end = mem[rd_ptr][ADDR_W];
  assign empty  = (count == '0);

endmodule

// File: rtl/turbo_len_seq.sv
// Turbo length sequencer: queues PB commands and walks an index 0..len-1 per PB,
// with a running start offset inside each burst and zero bubble between PBs.
module turbo_len_seq
  import turbo_len_seq_pkg::*;
#(
  parameter int ADDR_W     = 12,
  parameter int FIFO_DEPTH = 2,
  parameter int LEN_PB16   = LEN_PB16_DEF,
  parameter int LEN_PB136  = LEN_PB136_DEF,
  parameter int LEN_PB520  = LEN_PB520_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_vld,
  output logic              cmd_rdy,
  input  logic [1:0]        pb_size,
  input  logic [ADDR_W-1:0] cfg_len,
  input  logic              burst_end,
  input  logic              out_rdy,
  input  logic              abort,
  output logic [ADDR_W-1:0] enable,
  output logic [ADDR_W-1:0] pb_offset,
  output logic              dout_vld,
  output logic              pb_first,
  output logic              pb_last,
  output logic              cmd_err
);

  localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);

  logic [ADDR_W-1:0] cmd_len;
  logic              cmd_acc;
  logic              cmd_bad;
  logic              push;
  logic              pop;
  logic              fifo_empty;
  logic [ADDR_W-1:0] head_len;
  logic              head_end;
  logic              beat_last;
  state_t            state;
  logic [ADDR_W-1:0] cur_len;
  logic              cur_end;

  always_comb begin
    cmd_len = cfg_len;
    case (pb_size)
      PB_SIZE_16:  cmd_len = ADDR_W'(LEN_PB16);
      PB_SIZE_136: cmd_len = ADDR_W'(LEN_PB136);
      PB_SIZE_520: cmd_len = ADDR_W'(LEN_PB520);
      default:     cmd_len = cfg_len;
    endcase
  end

  // A zero-length custom PB would never terminate, so it is refused outright.
  assign cmd_acc   = cmd_vld && cmd_rdy && !abort;
  assign cmd_bad   = cmd_acc && (pb_size == PB_SIZE_CUSTOM) && (cfg_len == '0);
  assign push      = cmd_acc && !cmd_bad;
  assign beat_last = (state == RUN) && out_rdy && (enable == cur_len - ONE);
  assign pop       = !fifo_empty && !abort && ((state == IDLE) || beat_last);

  turbo_len_fifo #(
    .ADDR_W (ADDR_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .flush  (abort),
    .push   (push),
    .wr_len (cmd_len),
    .wr_end (burst_end),
    .pop    (pop),
    .rd_len (head_len),
    .rd_end (head_end),
    .empty  (fifo_empty),
    .wr_rdy (cmd_rdy)
  );

  always_ff @(posedge clk) begin
    if (rst) cmd_err <= 1'b0;
    else     cmd_err <= cmd_bad;
  end

  always_ff @(posedge clk) begin
    if (rst || abort) begin
      state     <= IDLE;
      enable    <= '0;
      pb_offset <= '0;
      dout_vld  <= 1'b0;
      pb_first  <= 1'b0;
      pb_last   <= 1'b0;
      cur_len   <= '0;
      cur_end   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (!fifo_empty) begin
            state     <= RUN;
            enable    <= '0;
            pb_offset <= '0;
            dout_vld  <= 1'b1;
            pb_first  <= 1'b1;
            pb_last   <= (head_len == ONE);
            cur_len   <= head_len;
            cur_end   <= head_end;
          end
        end
        RUN: begin
          if (out_rdy) begin
            if (enable == cur_len - ONE) begin
              if (!fifo_empty) begin
                enable    <= '0;
                pb_offset <= cur_end ? '0 : pb_offset + cur_len;
                pb_first  <= 1'b1;
                pb_last   <= (head_len == ONE);
                cur_len   <= head_len;
                cur_end   <= head_end;
              end else begin
                state     <= IDLE;
                enable    <= '0;
                pb_offset <= '0;
                dout_vld  <= 1'b0;
                pb_first  <= 1'b0;
                pb_last   <= 1'b0;
              end
            end else begin
              enable   <= enable + ONE;
              pb_first <= 1'b0;
              pb_last  <= (enable + ONE == cur_len - ONE);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
